// File: rtl/sseg_capture_if.sv
//------------------------------------------------------------------------------
// Module   : sseg_capture_if
// Purpose  : Bundles the seven-segment scan inputs and the decoded frame
//            outputs of sseg_capture into one interface.
// Signals  : sseg[6:0]    segment lines {g,f,e,d,c,b,a}, active-low
//            an[3:0]      digit anodes, active-low
//            bcd[15:0]    last complete frame, digit i in bcd[4i+3:4i]
//            err[3:0]     per-digit undecodable-pattern flags
//            frame_valid  one-cycle pulse when bcd/err update
//            stale        no frame completed within the timeout window
// Modports : master = stimulus/observer side, slave = capture core
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sseg_capture_if;
   logic [6:0]  sseg;
   logic [3:0]  an;
   logic [15:0] bcd;
   logic [3:0]  err;
   logic        frame_valid;
   logic        stale;

   modport master (
      output sseg, an,
      input  bcd, err, frame_valid, stale
   );

   modport slave (
      input  sseg, an,
      output bcd, err, frame_valid, stale
   );
endinterface

`default_nettype wire

// File: rtl/sseg_capture.sv
//------------------------------------------------------------------------------
// Module   : sseg_capture
// Purpose  : Snoops a multiplexed 4-digit seven-segment display bus, waits for
//            each digit to dwell stably, decodes it to BCD and publishes a
//            complete 4-digit frame once every digit has been captured.
// Ports    : clk  - single clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - sseg_capture_if.slave (sseg/an in, bcd/err/frame_valid/
//                   stale out)
// Params   : STABLE_CYCLES  - cycles a sample must persist before capture
//            TIMEOUT_CYCLES - cycles without a frame before stale is raised
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sseg_capture #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  wire logic     clk,
   input  wire logic     rst,
   sseg_capture_if.slave bus
);

   localparam logic [0:0]  ST_SETTLE  = 1'b0;
   localparam logic [0:0]  ST_HELD    = 1'b1;
   // A changed sample already counts as its first cycle, so capture happens
   // on the (STABLE_CYCLES-1)-th identical comparison.
   localparam logic [7:0]  DWELL_LAST = 8'(STABLE_CYCLES - 2);
   localparam logic [23:0] TO_LAST    = 24'(TIMEOUT_CYCLES - 1);

   // Decode active-low {g,f,e,d,c,b,a} into {err, digit}.
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1000000: r = {1'b0, 4'd0};
         7'b1111001: r = {1'b0, 4'd1};
         7'b0100100: r = {1'b0, 4'd2};
         7'b0110000: r = {1'b0, 4'd3};
         7'b0011001: r = {1'b0, 4'd4};
         7'b0010010: r = {1'b0, 4'd5};
         7'b0000010: r = {1'b0, 4'd6};
         7'b1111000: r = {1'b0, 4'd7};
         7'b0000000: r = {1'b0, 4'd8};
         7'b0010000: r = {1'b0, 4'd9};
         default:    r = {1'b1, 4'hF};
      endcase
      return r;
   endfunction

   logic [10:0] sample_q;
   logic [0:0]  state_q,   state_d;
   logic [7:0]  dwell_q,   dwell_d;
   logic [15:0] shadow_q,  shadow_d;
   logic [3:0]  sh_err_q,  sh_err_d;
   logic [3:0]  seen_q,    seen_d;
   logic [15:0] bcd_q,     bcd_d;
   logic [3:0]  err_q,     err_d;
   logic        fv_q,      fv_d;
   logic        stale_q,   stale_d;
   logic [23:0] to_q,      to_d;

   logic [10:0] w_sample;
   logic [3:0]  w_an_n;
   logic        w_sel;
   logic        w_same;
   logic        w_cap;
   logic [1:0]  w_idx;
   logic [4:0]  w_dec;
   logic        w_frame;
   logic        w_timeout;

   assign w_sample = {bus.an, bus.sseg};
   assign w_an_n   = ~bus.an;
   // Exactly one anode low: non-zero and a power of two.
   assign w_sel    = (w_an_n != 4'b0000) && ((w_an_n & (w_an_n - 4'd1)) == 4'b0000);
   assign w_same   = (w_sample == sample_q);
   assign w_dec    = f_decode(bus.sseg);

   always_comb begin
      w_idx = 2'd0;
      case (w_an_n)
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
   end

   // Per-dwell FSM: one capture per stable dwell, then park in HELD.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      w_cap   = 1'b0;
      if (!w_sel || !w_same) begin
         state_d = ST_SETTLE;
         dwell_d = 8'd0;
      end else if (state_q == ST_SETTLE) begin
         if (dwell_q == DWELL_LAST) begin
            w_cap   = 1'b1;
            state_d = ST_HELD;
            dwell_d = 8'd0;
         end else begin
            dwell_d = dwell_q + 8'd1;
         end
      end
   end

   assign w_frame   = (seen_q == 4'b1111);
   assign w_timeout = (to_q == TO_LAST);

   always_comb begin
      shadow_d = shadow_q;
      sh_err_d = sh_err_q;
      if (w_cap) begin
         shadow_d[{w_idx, 2'b00} +: 4] = w_dec[3:0];
         sh_err_d[w_idx]               = w_dec[4];
      end
   end

   // Frame completion wins over timeout when both land on the same edge.
   always_comb begin
      seen_d  = (w_frame || w_timeout) ? 4'b0000 : seen_q;
      if (w_cap) begin
         seen_d = seen_d | w_an_n;
      end
      to_d    = (w_frame || w_timeout) ? 24'd0 : to_q + 24'd1;
      fv_d    = w_frame;
      bcd_d   = w_frame ? shadow_q : bcd_q;
      err_d   = w_frame ? sh_err_q : err_q;
      stale_d = stale_q;
      if (w_frame) begin
         stale_d = 1'b0;
      end else if (w_timeout) begin
         stale_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_q <= 11'h7FF;
         state_q  <= ST_SETTLE;
         dwell_q  <= 8'd0;
         shadow_q <= 16'h0000;
         sh_err_q <= 4'b0000;
         seen_q   <= 4'b0000;
         bcd_q    <= 16'h0000;
         err_q    <= 4'b0000;
         fv_q     <= 1'b0;
         stale_q  <= 1'b0;
         to_q     <= 24'd0;
      end else begin
         sample_q <= w_sample;
         state_q  <= state_d;
         dwell_q  <= dwell_d;
         shadow_q <= shadow_d;
         sh_err_q <= sh_err_d;
         seen_q   <= seen_d;
         bcd_q    <= bcd_d;
         err_q    <= err_d;
         fv_q     <= fv_d;
         stale_q  <= stale_d;
         to_q     <= to_d;
      end
   end

   assign bus.bcd         = bcd_q;
   assign bus.err         = err_q;
   assign bus.frame_valid = fv_q;
   assign bus.stale       = stale_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_sseg_capture
// Purpose  : Directed self-checking bench for sseg_capture (STABLE_CYCLES=4,
//            TIMEOUT_CYCLES=64).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sseg_capture;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cyc;
   int   fv_cnt;
   int   fv_cyc;
   logic stale_at_fv;
   logic [6:0] pat [0:9];

   sseg_capture_if bus ();

   sseg_capture #(
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and log any frame_valid pulse seen there.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.frame_valid === 1'b1) begin
         fv_cnt++;
         fv_cyc      = cyc;
         stale_at_fv = bus.stale;
      end
   endtask

   task automatic hold(input int d, input logic [6:0] p, input int n);
      logic [3:0] a;
      a        = 4'b0001 << d;
      bus.an   = ~a;
      bus.sseg = p;
      repeat (n) step();
   endtask

   task automatic idle(input logic [3:0] a, input int n);
      bus.an   = a;
      bus.sseg = 7'b1111111;
      repeat (n) step();
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      cyc         = 0;
      fv_cnt      = 0;
      fv_cyc      = 0;
      stale_at_fv = 1'b0;
      pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
      pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
      pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
      pat[9] = 7'b0010000;

      // Reset state
      bus.an   = 4'b1111;
      bus.sseg = 7'b1111111;
      rst      = 1'b1;
      #1 rst   = 1'b0;
      #1;
      check("rst_bcd",   32'(bus.bcd),         32'h0);
      check("rst_err",   32'(bus.err),         32'h0);
      check("rst_fv",    32'(bus.frame_valid), 32'h0);
      check("rst_stale", 32'(bus.stale),       32'h0);
      step();
      step();
      rst = 1'b1;

      // Basic scan 3..0 = 4,7,0,9
      fv_cnt = 0;
      hold(3, pat[4], 8); hold(2, pat[7], 8); hold(1, pat[0], 8); hold(0, pat[9], 8);
      idle(4'b1111, 2);
      check("scan_fv_cnt", 32'(fv_cnt),    32'd1);
      check("scan_bcd",    32'(bus.bcd),   32'h4709);
      check("scan_err",    32'(bus.err),   32'h0);
      check("scan_stale",  32'(bus.stale), 32'h0);

      // Digit 1 held only 3 cycles must not be captured
      fv_cnt = 0;
      hold(3, pat[5], 8); hold(2, pat[6], 8); hold(1, pat[8], 3); hold(0, pat[2], 8);
      check("short_no_fv", 32'(fv_cnt), 32'd0);
      hold(1, pat[8], 4);
      idle(4'b1111, 2);
      check("short_fv_cnt", 32'(fv_cnt),  32'd1);
      check("short_bcd",    32'(bus.bcd), 32'h5682);
      check("short_err",    32'(bus.err), 32'h0);

      // Blank digit 2 decodes as error
      fv_cnt = 0;
      hold(3, pat[1], 8); hold(2, 7'b1111111, 8); hold(1, pat[2], 8); hold(0, pat[3], 8);
      idle(4'b1111, 2);
      check("blank_fv_cnt", 32'(fv_cnt),  32'd1);
      check("blank_bcd",    32'(bus.bcd), 32'h1F23);
      check("blank_err",    32'(bus.err), 32'h4);

      // Non-selectable anode patterns between digits
      fv_cnt = 0;
      hold(3, pat[1], 8);
      bus.an = 4'b0011; bus.sseg = pat[8]; repeat (5) step();
      hold(2, pat[2], 8);
      idle(4'b1111, 5);
      hold(1, pat[3], 8);
      bus.an = 4'b0011; bus.sseg = pat[8]; repeat (5) step();
      hold(0, pat[4], 8);
      idle(4'b1111, 2);
      check("nsel_fv_cnt", 32'(fv_cnt),  32'd1);
      check("nsel_bcd",    32'(bus.bcd), 32'h1234);
      check("nsel_err",    32'(bus.err), 32'h0);

      // Timeout with only three digits scanned
      fv_cnt = 0;
      hold(3, pat[0], 8); hold(2, pat[0], 8); hold(1, pat[0], 8);
      idle(4'b1111, 1);
      while (cyc < fv_cyc + 63) step();
      check("to_stale_before", 32'(bus.stale), 32'h0);
      check("to_no_fv",        32'(fv_cnt),    32'd0);
      step();
      check("to_stale_at64",   32'(bus.stale), 32'h1);
      check("to_bcd_kept",     32'(bus.bcd),   32'h1234);
      hold(3, pat[9], 8); hold(2, pat[8], 8); hold(1, pat[7], 8); hold(0, pat[6], 8);
      idle(4'b1111, 2);
      check("to_fv_cnt",       32'(fv_cnt),      32'd1);
      check("to_stale_at_fv",  32'(stale_at_fv), 32'h0);
      check("to_stale_after",  32'(bus.stale),   32'h0);
      check("to_bcd_new",      32'(bus.bcd),     32'h9876);

      // Asynchronous reset mid-frame discards partial captures
      fv_cnt = 0;
      hold(3, pat[2], 8); hold(2, pat[5], 8); hold(1, pat[3], 2);
      #2 rst = 1'b0;
      #1;
      check("arst_bcd",   32'(bus.bcd),         32'h0);
      check("arst_err",   32'(bus.err),         32'h0);
      check("arst_fv",    32'(bus.frame_valid), 32'h0);
      check("arst_stale", 32'(bus.stale),       32'h0);
      step();
      rst = 1'b1;
      hold(1, pat[3], 8); hold(0, pat[4], 8);
      idle(4'b1111, 2);
      check("arst_partial_no_fv", 32'(fv_cnt), 32'd0);
      hold(3, pat[2], 8); hold(2, pat[5], 8);
      idle(4'b1111, 2);
      check("arst_fv_cnt", 32'(fv_cnt),  32'd1);
      check("arst_bcd_new", 32'(bus.bcd), 32'h2534);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: cycles without a completed frame before stale is raised (legal range 16..2^24-1).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sseg, input, 7: segment lines {g,f,e,d,c,b,a}, active-low (0 = segment lit).
REQ-006 SHALL have port an, input, 4: digit anodes, active-low; an[i]=0 selects digit i.
REQ-007 SHALL have port bcd, output, 16: last complete frame, digit i in bcd[4i+3:4i].
REQ-008 SHALL have port err, output, 4: err[i]=1 means digit i held an undecodable pattern in the last frame.
REQ-009 SHALL have port frame_valid, output, 1: one-cycle pulse when bcd/err update.
REQ-010 SHALL have port stale, output, 1: no frame completed within TIMEOUT_CYCLES.

Function
REQ-011 SHALL register {an, sseg} every cycle and compare it with the previous registered sample.
REQ-012 SHALL treat a sample as selectable only when an has exactly one bit low; 4'b1111, or two or more bits low, SHALL be non-selectable.
REQ-013 SHALL run a per-dwell FSM with states SETTLE and HELD; a changed or non-selectable sample forces SETTLE and clears the dwell counter.
REQ-014 SHALL, in SETTLE, increment the dwell counter on each identical selectable sample; when the sample has been identical for STABLE_CYCLES consecutive cycles, capture it and go to HELD.
REQ-015 SHALL capture exactly once per dwell; HELD persists until the sample changes.
REQ-016 SHALL decode, on capture, 0..9 from active-low patterns 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
REQ-017 SHALL store any other pattern as digit 4'hF with the shadow error bit for that digit set; a valid pattern clears it.
REQ-018 SHALL write captures into a shadow register and set seen-mask bit i; a recapture of a digit already seen overwrites its shadow value.
REQ-019 SHALL, on the edge after the capture that makes the seen mask 4'b1111, copy shadow to bcd/err, pulse frame_valid for exactly one cycle, and clear the seen mask.
REQ-020 SHALL keep bcd/err constant between frame_valid pulses.
REQ-021 SHALL count cycles since the last frame_valid (or since reset); on reaching TIMEOUT_CYCLES, set stale, clear the seen mask, and restart the count.
REQ-022 SHALL clear stale in the same cycle frame_valid pulses, while bcd keeps its last value during stale.
REQ-023 SHALL, when frame completion and timeout coincide, give completion priority: frame_valid=1, stale=0, count restarted.

Reset
REQ-024 SHALL, while rst=0, force bcd=16'h0000, err=4'b0000, frame_valid=0, stale=0, seen mask=0, dwell state SETTLE with counter 0, timeout count 0, and sample register {4'b1111,7'b1111111}.
REQ-025 SHALL discard any partial frame when reset is asserted mid-operation; the first frame after release needs all four digits re-captured.

Verification
REQ-026 SHALL cover: scan digits 3,2,1,0 with values 4,7,0,9, each held 8 cycles -> one frame_valid pulse, bcd=16'h4709, err=0.
REQ-027 SHALL cover: digit 1 held 3 cycles (STABLE_CYCLES=4), then anode change -> no capture of digit 1 and no frame_valid until digit 1 dwells at least 4 cycles.
REQ-028 SHALL cover: digit 2 driven with 7'b1111111 in a full scan -> bcd[11:8]=4'hF, err=4'b0100, frame_valid pulses.
REQ-029 SHALL cover: an=4'b0011 or 4'b1111 between digits -> no captures during those cycles; a following clean scan of 1,2,3,4 gives bcd=16'h1234.
REQ-030 SHALL cover: TIMEOUT_CYCLES=64 with only 3 digits scanned -> stale=1 at cycle 64, bcd unchanged; next full scan -> frame_valid=1 and stale=0.
REQ-031 SHALL cover: rst pulled low after 2 digits captured -> all outputs 0 immediately (asynchronous); after release, 4 fresh digits are required for frame_valid.
